// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter (d_wb = port 0, s_wb = port 1) onto one memory port, with a watchdog.
// Optional macro WB_ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module wb_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,

  // Port 0: data cache
  input  logic [11:0]  d_wb_adr_i,
  input  logic [127:0] d_wb_dat_m_i,
  output logic [127:0] d_wb_dat_s_o,
  input  logic [15:0]  d_wb_sel_i,
  input  logic         d_wb_we_i,
  input  logic         d_wb_stb_i,
  input  logic         d_wb_cyc_i,
  output logic         d_wb_ack_o,
  output logic         d_wb_rty_o,

  // Port 1: stream buffer
  input  logic [11:0]  s_wb_adr_i,
  input  logic [127:0] s_wb_dat_m_i,
  output logic [127:0] s_wb_dat_s_o,
  input  logic [15:0]  s_wb_sel_i,
  input  logic         s_wb_we_i,
  input  logic         s_wb_stb_i,
  input  logic         s_wb_cyc_i,
  output logic         s_wb_ack_o,
  output logic         s_wb_rty_o,

  // Physical memory
  output logic [11:0]  wb_adr_o,
  output logic [127:0] wb_dat_m_o,
  input  logic [127:0] wb_dat_s_i,
  output logic [15:0]  wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_stb_o,
  output logic         wb_cyc_o,
  input  logic         wb_ack_i,
  input  logic         wb_rty_i
);

  typedef enum logic [1:0] {
    StIdle,
    StGrant0,
    StGrant1
  } state_e;

  localparam bit         WatchdogEn  = (TIMEOUT != 0);
  localparam logic [7:0] TimeoutLast = WatchdogEn ? 8'(TIMEOUT - 1) : 8'd0;

  state_e     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] timer_q, timer_d;

  logic req0, req1;
  logic granted, own1;
  logic owner_cyc, owner_stb;
  logic mem_resp;
  logic timeout;
  logic tie_pick1;

  assign req0      = d_wb_cyc_i & d_wb_stb_i;
  assign req1      = s_wb_cyc_i & s_wb_stb_i;
  assign granted   = (state_q != StIdle);
  assign own1      = (state_q == StGrant1);
  assign owner_cyc = own1 ? s_wb_cyc_i : d_wb_cyc_i;
  assign owner_stb = own1 ? s_wb_stb_i : d_wb_stb_i;
  assign mem_resp  = wb_ack_i | wb_rty_i;

  // An owner that has already dropped CYC is treated as an abort, not a timeout.
  assign timeout = WatchdogEn & granted & ~mem_resp & owner_cyc & (timer_q == TimeoutLast);

`ifdef WB_ARB_FIXED_PRIO_EN
  assign tie_pick1 = 1'b0;
`else
  assign tie_pick1 = ~last_grant_q;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    unique case (state_q)
      StIdle: begin
        timer_d = 8'd0;
        if (req0 && req1) begin
          state_d = tie_pick1 ? StGrant1 : StGrant0;
        end else if (req0) begin
          state_d = StGrant0;
        end else if (req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0, StGrant1: begin
        if (mem_resp || !owner_cyc || timeout) begin
          state_d      = StIdle;
          last_grant_d = own1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      timer_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
    end
  end

  // Outputs are gated by rst so a transfer caught by reset sees CYC drop and no response.
  always_comb begin
    wb_adr_o   = 12'd0;
    wb_dat_m_o = 128'd0;
    wb_sel_o   = 16'd0;
    wb_we_o    = 1'b0;
    wb_stb_o   = 1'b0;
    wb_cyc_o   = 1'b0;
    d_wb_ack_o = 1'b0;
    d_wb_rty_o = 1'b0;
    s_wb_ack_o = 1'b0;
    s_wb_rty_o = 1'b0;
    if (granted && !rst) begin
      wb_adr_o   = own1 ? s_wb_adr_i   : d_wb_adr_i;
      wb_dat_m_o = own1 ? s_wb_dat_m_i : d_wb_dat_m_i;
      wb_sel_o   = own1 ? s_wb_sel_i   : d_wb_sel_i;
      wb_we_o    = own1 ? s_wb_we_i    : d_wb_we_i;
      wb_stb_o   = owner_stb & ~timeout;
      wb_cyc_o   = owner_cyc & ~timeout;
      d_wb_ack_o = ~own1 & wb_ack_i;
      d_wb_rty_o = ~own1 & (wb_rty_i | timeout);
      s_wb_ack_o = own1 & wb_ack_i;
      s_wb_rty_o = own1 & (wb_rty_i | timeout);
    end
  end

  assign d_wb_dat_s_o = wb_dat_s_i;
  assign s_wb_dat_s_o = wb_dat_s_i;

endmodule
